formation_move: RTL

FORMATION_MOVE -- requirements
Module: formation_move

---
 rtl/formation_move.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/formation_move.sv
// Formation motion controller. It sweeps the invader formation right and left, drops it at each wall,
// and lands it at the y limit. The step rate slows down as more invaders are alive.
//
// state    | meaning
// ---------+------------------------------------------------------
// S_IDLE   | stopped, waiting for game_start
// S_RIGHT  | stepping right by X_STEP per tick
// S_DROP_R | at the right wall, next tick drops by Y_STEP
// S_LEFT   | stepping left by X_STEP per tick
// S_DROP_L | at the left wall, next tick drops by Y_STEP
// S_LANDED | reached Y_LIMIT, frozen until game_start
module formation_move #(
  parameter int X_START          = 0,
  parameter int Y_START          = 0,
  parameter int X_MIN            = 0,
  parameter int X_MAX            = 100,
  parameter int X_STEP           = 2,
  parameter int Y_STEP           = 16,
  parameter int Y_LIMIT          = 600,
  parameter int ALIVE_W          = 6,
  parameter int MIN_PERIOD       = 1_000_000,
  parameter int PERIOD_PER_ALIVE = 75_000
) (
  input  logic               clk65MHz,
  input  logic               rst_n,
  input  logic               game_start,
  input  logic               pause,
  input  logic [ALIVE_W-1:0] alive_count,
  output logic [9:0]         xpos,
  output logic [9:0]         ypos,
  output logic               step,
  output logic               dir_left,
  output logic               landed
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RIGHT  = 3'd1;
  localparam logic [2:0] S_DROP_R = 3'd2;
  localparam logic [2:0] S_LEFT   = 3'd3;
  localparam logic [2:0] S_DROP_L = 3'd4;
  localparam logic [2:0] S_LANDED = 3'd5;

  localparam logic [9:0]  X_START10 = 10'(X_START);
  localparam logic [9:0]  Y_START10 = 10'(Y_START);
  localparam logic [9:0]  X_MIN10   = 10'(X_MIN);
  localparam logic [9:0]  X_MAX10   = 10'(X_MAX);
  localparam logic [9:0]  Y_LIMIT10 = 10'(Y_LIMIT);
  localparam logic [10:0] X_MIN11   = 11'(X_MIN);
  localparam logic [10:0] X_MAX11   = 11'(X_MAX);
  localparam logic [10:0] X_STEP11  = 11'(X_STEP);
  localparam logic [10:0] Y_STEP11  = 11'(Y_STEP);
  localparam logic [10:0] Y_LIMIT11 = 11'(Y_LIMIT);

  logic [2:0]  state_q, state_d;
  logic [31:0] count_q, count_d;
  logic [31:0] period_q, period_d;
  logic [9:0]  xpos_q, xpos_d;
  logic [9:0]  ypos_q, ypos_d;
  logic        step_q, step_d;

  logic [31:0] period_new;
  logic        count_end;
  logic [10:0] x_inc, x_dec, y_inc, x_left_bound;

  // The period is latched on every reload, so a change in alive_count only
  // affects the next step interval, not the one already in progress.
  assign period_new   = 32'(MIN_PERIOD) + 32'(alive_count) * 32'(PERIOD_PER_ALIVE);
  assign count_end    = (count_q == period_q - 32'd1);
  assign x_inc        = {1'b0, xpos_q} + X_STEP11;
  assign x_dec        = {1'b0, xpos_q} - X_STEP11;
  assign y_inc        = {1'b0, ypos_q} + Y_STEP11;
  assign x_left_bound = X_MIN11 + X_STEP11;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    period_d = period_q;
    xpos_d   = xpos_q;
    ypos_d   = ypos_q;
    step_d   = 1'b0;
    case (state_q)
      S_IDLE, S_LANDED: begin
        if (game_start) begin
          xpos_d   = X_START10;
          ypos_d   = Y_START10;
          count_d  = 32'd0;
          period_d = period_new;
          state_d  = S_RIGHT;
        end
      end
      S_RIGHT, S_DROP_R, S_LEFT, S_DROP_L: begin
        if (alive_count == '0) begin
          state_d = S_IDLE;
          count_d = 32'd0;
        end else if (!pause) begin
          if (count_end) begin
            count_d  = 32'd0;
            period_d = period_new;
            step_d   = 1'b1;
            case (state_q)
              S_RIGHT: begin
                if (x_inc >= X_MAX11) begin
                  xpos_d  = X_MAX10;
                  state_d = S_DROP_R;
                end else begin
                  xpos_d = x_inc[9:0];
                end
              end
              S_LEFT: begin
                if ({1'b0, xpos_q} <= x_left_bound) begin
                  xpos_d  = X_MIN10;
                  state_d = S_DROP_L;
                end else begin
                  xpos_d = x_dec[9:0];
                end
              end
              default: begin
                if (y_inc >= Y_LIMIT11) begin
                  ypos_d  = Y_LIMIT10;
                  state_d = S_LANDED;
                end else begin
                  ypos_d  = y_inc[9:0];
                  state_d = (state_q == S_DROP_R) ? S_LEFT : S_RIGHT;
                end
              end
            endcase
          end else begin
            count_d = count_q + 32'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk65MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      count_q  <= 32'd0;
      period_q <= 32'(MIN_PERIOD);
      xpos_q   <= X_START10;
      ypos_q   <= Y_START10;
      step_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      period_q <= period_d;
      xpos_q   <= xpos_d;
      ypos_q   <= ypos_d;
      step_q   <= step_d;
    end
  end

  assign xpos     = xpos_q;
  assign ypos     = ypos_q;
  assign step     = step_q;
  assign dir_left = (state_q == S_LEFT) || (state_q == S_DROP_R);
  assign landed   = (state_q == S_LANDED);

endmodule
